// File: rtl/inv_factorial.sv
// rtl/inv_factorial.sv - iterative inverse factorial: largest n with factorial(n) <= target, plus exact-match flag.
// Optional remainder outputs are enabled by defining INV_FACTORIAL_REM_EN.
module inv_factorial #(
    parameter int DATA_W   = 32,
    parameter int N_MAX    = 12,
    parameter int HALVE_IN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_val,
    output logic              ready,
    output logic              done,
    output logic [3:0]        n_out,
`ifdef INV_FACTORIAL_REM_EN
    output logic [DATA_W-1:0] fact_out,
    output logic [DATA_W-1:0] rem_out,
`endif
    output logic              exact
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [3:0] K_MAX = 4'(N_MAX);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_target;
    logic [DATA_W-1:0]   r_acc;
    logic [3:0]          r_k;
    logic                r_odd;
    logic [3:0]          r_n;
    logic                r_exact;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_zero;
    logic                w_stop;
    logic [DATA_W-1:0]   w_target_in;
    logic                w_odd_in;

    // Full-width product so an overflowing factorial still compares as "too big".
    assign w_prod = {{DATA_W{1'b0}}, r_acc} * {{(2*DATA_W-4){1'b0}}, r_k + 4'd1};
    assign w_zero = (r_target == '0);
    assign w_stop = w_zero || (r_k == K_MAX) || (w_prod > {{DATA_W{1'b0}}, r_target});

    assign w_target_in = (HALVE_IN != 0) ? (in_val >> 1) : in_val;
    assign w_odd_in    = (HALVE_IN != 0) && in_val[0];

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_next = S_CALC;
            end
            S_CALC: begin
                if (w_stop) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_odd    <= 1'b0;
            r_n      <= '0;
            r_exact  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target <= w_target_in;
                        r_odd    <= w_odd_in;
                        r_acc    <= {{(DATA_W-1){1'b0}}, 1'b1};
                        r_k      <= 4'd1;
                    end
                end
                S_CALC: begin
                    if (w_stop) begin
                        r_n     <= w_zero ? 4'd0 : r_k;
                        r_exact <= w_zero ? ~r_odd : ((r_acc == r_target) & ~r_odd);
                    end else begin
                        r_acc <= w_prod[DATA_W-1:0];
                        r_k   <= r_k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INV_FACTORIAL_REM_EN
    logic [DATA_W-1:0] r_fact;
    logic [DATA_W-1:0] r_rem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fact <= '0;
            r_rem  <= '0;
        end else if (r_state == S_CALC && w_stop) begin
            r_fact <= w_zero ? '0 : r_acc;
            r_rem  <= w_zero ? '0 : (r_target - r_acc);
        end
    end

    assign fact_out = r_fact;
    assign rem_out  = r_rem;
`endif

    assign n_out = r_n;
    assign exact = r_exact;

endmodule

// File: tb/tb_inv_factorial.sv
// tb/tb_inv_factorial.sv - randomized + directed bench for inv_factorial (HALVE_IN=1 and HALVE_IN=0 instances).
module tb_inv_factorial;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_val = '0;
    logic [1:0]  rdy, dn, ex;
    logic [3:0]  nout [2];
`ifdef INV_FACTORIAL_REM_EN
    logic [31:0] fout [2];
    logic [31:0] rout [2];
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inv_factorial #(.DATA_W(32), .N_MAX(12), .HALVE_IN(1)) u_h (
        .clk(clk), .reset(reset), .start(start), .in_val(in_val),
        .ready(rdy[0]), .done(dn[0]), .n_out(nout[0]),
`ifdef INV_FACTORIAL_REM_EN
        .fact_out(fout[0]), .rem_out(rout[0]),
`endif
        .exact(ex[0]));

    inv_factorial #(.DATA_W(32), .N_MAX(12), .HALVE_IN(0)) u_r (
        .clk(clk), .reset(reset), .start(start), .in_val(in_val),
        .ready(rdy[1]), .done(dn[1]), .n_out(nout[1]),
`ifdef INV_FACTORIAL_REM_EN
        .fact_out(fout[1]), .rem_out(rout[1]),
`endif
        .exact(ex[1]));

    function automatic longint fact(input int k);
        longint f;
        if (k == 0) return 0;
        f = 1;
        for (int j = 2; j <= k; j++) f = f * j;
        return f;
    endfunction

    // Reference: scan every n and keep the largest whose factorial fits under the target.
    function automatic void ref_inv(input logic [31:0] v, input bit halve,
                                    output int n, output bit exact_o, output logic [31:0] f_o,
                                    output logic [31:0] r_o);
        longint tgt;
        bit odd;
        tgt = halve ? longint'(v >> 1) : longint'(v);
        odd = halve && v[0];
        n = 0;
        for (int j = 1; j <= 12; j++)
            if (fact(j) <= tgt) n = j;
        exact_o = (fact(n) == tgt) && !odd;
        f_o = 32'(fact(n));
        r_o = 32'(tgt - fact(n));
    endfunction

    task automatic check(input string name, input int inst, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%0d exp=%0d at %0t", name, inst, got, exp, $time);
        end
    endtask

    bit          m_ready [2];
    bit          m_done  [2];
    int          m_cnt   [2];
    int          m_n     [2];
    int          m_pn    [2];
    bit          m_ex    [2];
    bit          m_pe    [2];
    logic [31:0] m_f     [2];
    logic [31:0] m_pf    [2];
    logic [31:0] m_r     [2];
    logic [31:0] m_pr    [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = 1'b1; m_done[i] = 1'b0; m_cnt[i] = 0;
            m_n[i] = 0; m_ex[i] = 1'b0; m_f[i] = '0; m_r[i] = '0;
        end
    end

    // Model: a job occupies max(n,1) busy cycles, then a single done cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_ready[i] = 1'b1; m_done[i] = 1'b0; m_cnt[i] = 0;
                m_n[i] = 0; m_ex[i] = 1'b0; m_f[i] = '0; m_r[i] = '0;
            end else if (m_done[i]) begin
                m_done[i]  = 1'b0;
                m_ready[i] = 1'b1;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_done[i] = 1'b1;
                    m_n[i] = m_pn[i]; m_ex[i] = m_pe[i]; m_f[i] = m_pf[i]; m_r[i] = m_pr[i];
                end
            end else if (m_ready[i] && start) begin
                ref_inv(in_val, (i == 0), m_pn[i], m_pe[i], m_pf[i], m_pr[i]);
                m_cnt[i]   = (m_pn[i] > 1) ? m_pn[i] : 1;
                m_ready[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("ready", i, rdy[i], m_ready[i]);
                check("done",  i, dn[i],  m_done[i]);
                check("n_out", i, nout[i], m_n[i]);
                check("exact", i, ex[i],  m_ex[i]);
`ifdef INV_FACTORIAL_REM_EN
                check("fact_out", i, fout[i], m_f[i]);
                check("rem_out",  i, rout[i], m_r[i]);
`endif
            end
        end
    end

    // Issue one job, optionally poke a second start mid-CALC, and measure latency on one instance.
    task automatic run_job(input logic [31:0] v, input int inst, input int exp_n, input int exp_ex,
                           input int exp_lat, input bit poke);
        int t;
        t = 0;
        while (rdy != 2'b11 && t < 40) begin @(negedge clk); t++; end
        check("wait_ready", inst, (t < 40), 1);
        start = 1'b1; in_val = v;
        @(negedge clk);
        start = 1'b0;
        in_val = $urandom;
        t = 1;
        while (!dn[inst] && t < 40) begin
            if (poke && t == 2) begin start = 1'b1; in_val = 32'd2; end
            else start = 1'b0;
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check("latency", inst, t, exp_lat);
        check("job_n", inst, nout[inst], exp_n);
        check("job_exact", inst, ex[inst], exp_ex);
    endtask

    task automatic pin_model(input logic [31:0] v, input bit halve, input int en, input int ee);
        int n; bit e; logic [31:0] f, r;
        ref_inv(v, halve, n, e, f, r);
        check("model_n", halve, n, en);
        check("model_exact", halve, e, ee);
    endtask

    initial begin
        pin_model(32'd48, 1'b1, 4, 1);
        pin_model(32'd49, 1'b1, 4, 0);
        pin_model(32'd0, 1'b0, 0, 1);
        pin_model(32'd479001600, 1'b0, 12, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst_ready", 0, rdy[0], 1);
        check("rst_done", 0, dn[0], 0);
        check("rst_n", 0, nout[0], 0);
        check("rst_exact", 0, ex[0], 0);
        chk_en = 1'b1;

        run_job(32'd48, 0, 4, 1, 5, 1'b0);
        run_job(32'd48, 0, 4, 1, 5, 1'b1);
        run_job(32'd48, 1, 4, 0, 5, 1'b0);
        run_job(32'd50, 0, 4, 0, 5, 1'b0);
        run_job(32'd49, 0, 4, 0, 5, 1'b0);
        run_job(32'd0, 0, 0, 1, 2, 1'b0);
        run_job(32'd2, 0, 1, 1, 2, 1'b0);
        run_job(32'hFFFFFFFF, 1, 12, 0, 13, 1'b0);
        run_job(32'd479001600, 1, 12, 1, 13, 1'b0);
        run_job(32'd479001600, 0, 11, 0, 12, 1'b0);

        // Abort mid-CALC: no done afterwards, outputs back to reset values.
        @(negedge clk);
        start = 1'b1; in_val = 32'd48;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        check("abort_ready", 0, rdy[0], 1);
        check("abort_n", 0, nout[0], 0);
        repeat (6) begin
            @(negedge clk);
            check("abort_nodone", 0, dn[0], 0);
        end

        for (int c = 0; c < 4000; c++) begin
            int k;
            k = $urandom_range(0, 12);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: in_val = $urandom;
                1: in_val = 32'(2 * fact(k)) + 32'($urandom_range(0, 2)) - 32'd1;
                2: in_val = $urandom_range(0, 63);
                default: in_val = 32'(fact(k));
            endcase
            reset = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        reset = 1'b1; start = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
